// File: rtl/latch_bus_writer.sv
// Writer end of a latch-enable data bus: small FIFO feeding a setup/strobe/hold sequencer.
// Optional readback checker enabled by defining LATCH_BUS_WRITER_READBACK_EN.
module latch_bus_writer #(
  parameter int unsigned DW       = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned EN_PULSE = 1
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_valid,
  input  logic [DW-1:0]            i_data,
  output logic                     o_ready,
  output logic [DW-1:0]            o_y,
  output logic                     o_en,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_level
`ifdef LATCH_BUS_WRITER_READBACK_EN
  ,
  input  logic [DW-1:0]            i_rb,
  output logic                     o_rb_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (EN_PULSE > 1) ? $clog2(EN_PULSE) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   count_q, count_d;
  logic [DW-1:0]   y_q, y_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   mem [DEPTH];
  logic            push, pop;

  // o_ready comes from a register, so push never depends combinationally on itself
  assign push = i_valid & ready_q;
  assign pop  = ((state_q == IDLE) || (state_q == HOLD)) && (count_q != '0);

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    state_d = pop ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    y_d     = y_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    if (pop) y_d = mem[rptr_q];
    if (state_q == SETUP)
      cnt_d = CW'(EN_PULSE - 1);
    else if ((state_q == STROBE) && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
    en_d    = (state_d == STROBE);
    count_d = count_q + LW'(push) - LW'(pop);
    busy_d  = (state_d != IDLE) || (count_d != '0);
    ready_d = (count_d != LW'(DEPTH));
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q   <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr_q] <= i_data;
  end

  assign o_ready = ready_q;
  assign o_y     = y_q;
  assign o_en    = en_q;
  assign o_busy  = busy_q;
  assign o_level = count_q;

`ifdef LATCH_BUS_WRITER_READBACK_EN
  logic rb_err_q, rb_err_d;

  // Sticky flag; the sequencer keeps running regardless of mismatches
  always_comb begin
    rb_err_d = rb_err_q;
    if ((state_q == HOLD) && (i_rb != y_q)) rb_err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) rb_err_q <= 1'b0;
    else           rb_err_q <= rb_err_d;
  end

  assign o_rb_err = rb_err_q;
`endif

endmodule

// File: tb/tb_latch_bus_writer.sv
// Directed bench for latch_bus_writer: EN_PULSE=1 instance (a) and EN_PULSE=3 instance (b).
// Readback checks are included when LATCH_BUS_WRITER_READBACK_EN is defined.
module tb_latch_bus_writer;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic [7:0] y;
    logic       en;
    logic       busy;
    logic [2:0] level;
  } vec_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, ready_b;
  logic [7:0] y_a, y_b;
  logic       en_a, en_b;
  logic       busy_a, busy_b;
  logic [2:0] level_a, level_b;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cap[$];
  logic       en_prev = 1'b0;

`ifdef LATCH_BUS_WRITER_READBACK_EN
  logic       rb_flip = 1'b0;
  logic [7:0] rb_a, rb_b;
  logic       rb_err_a, rb_err_b;
  assign rb_a = y_a ^ {7'b0, rb_flip};
  assign rb_b = y_b;
`endif

  latch_bus_writer #(.DW(8), .DEPTH(4), .EN_PULSE(1)) dut_a (
    .i_clk(clk), .i_arst_n(rst_a), .i_valid(valid_a), .i_data(data_a),
    .o_ready(ready_a), .o_y(y_a), .o_en(en_a), .o_busy(busy_a), .o_level(level_a)
`ifdef LATCH_BUS_WRITER_READBACK_EN
    , .i_rb(rb_a), .o_rb_err(rb_err_a)
`endif
  );

  latch_bus_writer #(.DW(8), .DEPTH(4), .EN_PULSE(3)) dut_b (
    .i_clk(clk), .i_arst_n(rst_b), .i_valid(valid_b), .i_data(data_b),
    .o_ready(ready_b), .o_y(y_b), .o_en(en_b), .o_busy(busy_b), .o_level(level_b)
`ifdef LATCH_BUS_WRITER_READBACK_EN
    , .i_rb(rb_b), .o_rb_err(rb_err_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record o_y at each rising o_en of instance a
  always @(posedge clk) begin
    if (en_a && !en_prev) cap.push_back(y_a);
    en_prev = en_a;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int sel, input vec_t v, input string tag);
    if (sel == 0) begin valid_a = v.valid; data_a = v.data; end
    else          begin valid_b = v.valid; data_b = v.data; end
    @(posedge clk); #1;
    if (sel == 0) begin
      chk({tag, ".ready"}, 32'(ready_a), 32'(v.ready));
      chk({tag, ".y"},     32'(y_a),     32'(v.y));
      chk({tag, ".en"},    32'(en_a),    32'(v.en));
      chk({tag, ".busy"},  32'(busy_a),  32'(v.busy));
      chk({tag, ".level"}, 32'(level_a), 32'(v.level));
    end else begin
      chk({tag, ".ready"}, 32'(ready_b), 32'(v.ready));
      chk({tag, ".y"},     32'(y_b),     32'(v.y));
      chk({tag, ".en"},    32'(en_b),    32'(v.en));
      chk({tag, ".busy"},  32'(busy_b),  32'(v.busy));
      chk({tag, ".level"}, 32'(level_b), 32'(v.level));
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] d);
    int k = 0;
    while (!ready_a && k < 50) begin @(posedge clk); #1; k++; end
    chk("push_ready", 32'(ready_a), 32'd1);
    valid_a = 1'b1; data_a = d;
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (busy_a && k < 100) begin @(posedge clk); #1; k++; end
    chk("idle_reached", 32'(busy_a), 32'd0);
  endtask

  vec_t va[$];
  vec_t vb[$];

  initial begin
    // Test 1: single word, EN_PULSE=1
    va.push_back(vec_t'{1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b1, 3'd1});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd0});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd0});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd0});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd0});
    // Test 2: back-to-back pushes fill the FIFO; 0x07 is refused while full
    va.push_back(vec_t'{1'b1, 8'h01, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd1});
    va.push_back(vec_t'{1'b1, 8'h02, 1'b1, 8'h01, 1'b0, 1'b1, 3'd1});
    va.push_back(vec_t'{1'b1, 8'h03, 1'b1, 8'h01, 1'b1, 1'b1, 3'd2});
    va.push_back(vec_t'{1'b1, 8'h04, 1'b1, 8'h01, 1'b0, 1'b1, 3'd3});
    va.push_back(vec_t'{1'b1, 8'h05, 1'b1, 8'h02, 1'b0, 1'b1, 3'd3});
    va.push_back(vec_t'{1'b1, 8'h06, 1'b0, 8'h02, 1'b1, 1'b1, 3'd4});
    va.push_back(vec_t'{1'b1, 8'h07, 1'b0, 8'h02, 1'b0, 1'b1, 3'd4});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 3'd3});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 3'd3});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 3'd3});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1, 3'd2});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 1'b1, 3'd2});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1, 3'd2});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b1, 3'd1});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 1'b1, 3'd1});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b1, 3'd1});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 1'b1, 3'd0});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 1'b1, 3'd0});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 1'b1, 3'd0});
    va.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 1'b0, 3'd0});
    // Test 3: EN_PULSE=3, o_en high three cycles, o_y steady
    vb.push_back(vec_t'{1'b1, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b1, 3'd1});
    vb.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 3'd0});
    vb.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1, 3'd0});
    vb.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1, 3'd0});
    vb.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1, 3'd0});
    vb.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 3'd0});
    vb.push_back(vec_t'{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 3'd0});

    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready", 32'(ready_a), 32'd1);
    chk("rst.y",     32'(y_a),     32'd0);
    chk("rst.en",    32'(en_a),    32'd0);
    chk("rst.busy",  32'(busy_a),  32'd0);
    chk("rst.level", 32'(level_a), 32'd0);
    chk("rst_b.en",  32'(en_b),    32'd0);
`ifdef LATCH_BUS_WRITER_READBACK_EN
    chk("rst.rb_err", 32'(rb_err_a), 32'd0);
`endif

    for (int i = 0; i < va.size(); i++) apply(0, va[i], $sformatf("a%0d", i));
    for (int i = 0; i < vb.size(); i++) apply(1, vb[i], $sformatf("b%0d", i));

    // Test 4: reset during STROBE with two words still queued
    valid_a = 1'b1; data_a = 8'h20; @(posedge clk); #1;
    data_a = 8'h21; @(posedge clk); #1;
    data_a = 8'h22; @(posedge clk); #1;
    valid_a = 1'b0;
    chk("pre_rst.en",    32'(en_a),    32'd1);
    chk("pre_rst.level", 32'(level_a), 32'd2);
    #2 rst_a = 1'b0;
    #1;
    chk("mid_rst.en",    32'(en_a),    32'd0);
    chk("mid_rst.y",     32'(y_a),     32'd0);
    chk("mid_rst.level", 32'(level_a), 32'd0);
    chk("mid_rst.ready", 32'(ready_a), 32'd1);
    chk("mid_rst.busy",  32'(busy_a),  32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    begin
      int highs = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (en_a) highs++;
      end
      chk("post_rst_pulses", 32'(highs), 32'd0);
    end

    // Test 5: simultaneous push/pop at level 2, then pointer wrap over 9 words
    cap.delete();
    valid_a = 1'b1; data_a = 8'h10; @(posedge clk); #1;
    data_a = 8'h11; @(posedge clk); #1;
    data_a = 8'h12; @(posedge clk); #1;
    valid_a = 1'b0; @(posedge clk); #1;
    chk("pp.level_before", 32'(level_a), 32'd2);
    valid_a = 1'b1; data_a = 8'h13; @(posedge clk); #1;
    valid_a = 1'b0;
    chk("pp.level_after", 32'(level_a), 32'd2);
    for (int i = 4; i < 9; i++) push_a(8'(8'h10 + i));
    wait_idle_a();
    chk("wrap.count", 32'(cap.size()), 32'd9);
    for (int i = 0; i < 9 && i < cap.size(); i++)
      chk($sformatf("wrap.word%0d", i), 32'(cap[i]), 32'(8'h10 + i));

`ifdef LATCH_BUS_WRITER_READBACK_EN
    // Test 6: corrupted readback on 0x80 sets a sticky error
    chk("rb.clean", 32'(rb_err_a), 32'd0);
    rb_flip = 1'b1;
    push_a(8'h80);
    wait_idle_a();
    chk("rb.set", 32'(rb_err_a), 32'd1);
    rb_flip = 1'b0;
    push_a(8'h81);
    push_a(8'h82);
    wait_idle_a();
    chk("rb.sticky", 32'(rb_err_a), 32'd1);
    #2 rst_a = 1'b0;
    #1 chk("rb.cleared", 32'(rb_err_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
